vproc_wr_scoreboard: RTL
========================

# vproc_wr_scoreboard

Vector-register write scoreboard for the vproc dispatch stage. It accepts per-instruction pending-write masks, such as those produced by the pending-write mask decoder, and holds them in a small table of in-flight slots. It stalls dispatch on RAW/WAW hazards against registers still pending. It clears masks per vreg as functional units write back, and reports slot retirement.

## Interface
Parameters:
- `SLOT_ID_W`, default 3: slot index width; the table has 2**SLOT_ID_W slots.
- `DONT_CARE_ZERO`, default 1'b0: drive don't-care outputs to zero instead of 'x.

Ports:
- `clk_i` input 1: clock. Single clock domain.
- `sync_rst_i` input 1: reset. Synchronous, active-high.
- `flush_i` input 1: discard all slots; same effect as reset.
- `issue_valid_i` input 1: dispatch offers an instruction.
- `issue_ready_o` output 1: instruction accepted this cycle when high together with valid.
- `issue_wr_mask_i` input 32: vregs the instruction will write (pending-write mask).
- `issue_rd_mask_i` input 32: vregs the instruction will read.
- `issue_id_o` output SLOT_ID_W: slot allocated to the accepted instruction.
- `clear_valid_i` input 1: a unit reports writeback progress.
- `clear_id_i` input SLOT_ID_W: slot being cleared.
- `clear_mask_i` input 32: vregs whose write has completed.
- `pending_o` output 32: OR of all live slot masks (registered).
- `retire_valid_o` output 1: one-cycle pulse; a slot emptied.
- `retire_id_o` output SLOT_ID_W: slot that emptied.
- `busy_o` output 1: at least one slot is live.

## Operation
- State per slot:
  - `mask_q[32]`
  - `live_q`
- Slot allocation:
  - The lowest-index slot with `live_q==0` is allocated.
  - `issue_id_o` shows that index combinationally.
  - When all slots are live, `issue_id_o` is 0 (or 'x when `DONT_CARE_ZERO=0`).
- Hazard:
  - `haz = |((issue_rd_mask_i | issue_wr_mask_i) & pend_chk)`.
  - `pend_chk` is `pending_o` by default. See Configuration.
- Ready:
  - `issue_ready_o = !haz && (free slot exists || issue_wr_mask_i==0)`.
  - `issue_ready_o` is combinational from the payload inputs. Dispatch holds the payload stable while valid is high.
- Zero-mask issue (stores, xreg-result ops):
  - Accepted without allocating a slot.
  - No retire pulse is generated.
- Accepted non-zero issue: the allocated slot gets `mask_q <= issue_wr_mask_i` and `live_q <= 1`.
- Clear:
  - When `clear_valid_i` is high and `live_q[clear_id_i]` is set, `mask_q[clear_id_i] <= mask_q & ~clear_mask_i`.
  - Clear bits not set in the slot are ignored.
  - A clear to a non-live slot is ignored entirely.
- Retire:
  - Triggered when a clear leaves a live slot's mask at zero.
  - Next cycle: `live_q` goes to 0, `retire_valid_o` is 1, and `retire_id_o` is that slot.
  - At most one retire per cycle, since there is a single clear port.
- `pending_o` and `busy_o` are computed from registered state only.

## Timing
- Reset value of every output:
  - `pending_o` = 0
  - `busy_o` = 0
  - `retire_valid_o` = 0
  - `retire_id_o` = 0
  - `issue_ready_o` = 1 when issue inputs are zero
  - All `live_q` and `mask_q` = 0
- Issue to visibility:
  - An issue accepted in cycle N appears in `pending_o` in cycle N+1.
  - A dependent instruction is stalled from N+1 onward.
  - Back-to-back issues in N and N+1 with overlapping masks: the N+1 issue is stalled.
- Clear to visibility: a clear in cycle N drops its bits from `pending_o` in cycle N+1.
- Slot reuse:
  - A slot freed by a clear in cycle N reports its retire in N+1 and is allocatable from N+1.
  - An issue and a clear in the same cycle never target the same slot, because allocation only uses non-live slots.
- Flush and reset:
  - `flush_i` or `sync_rst_i` in cycle N zeroes all state by N+1.
  - Issue and clear in cycle N are discarded.
  - No retire pulses are emitted for flushed slots.
  - Reset and flush may arrive mid-operation with any slot state.
- `issue_ready_o` is forced to 0 during `flush_i` and `sync_rst_i`.

## Configuration
- `VPROC_WR_SB_CLEAR_BYPASS_EN` defined:
  - `pend_chk = pending_o & ~(clear_valid_i && live_q[clear_id_i] ? clear_mask_i : 0)`.
  - An issue waiting on a register clears its hazard in the same cycle the clear arrives.
- Not defined:
  - `pend_chk = pending_o`.
  - Such an issue is accepted one cycle later.
- Slot allocation and retire timing are identical either way.

## Test plan
- Reset, then issue wr=0x0000_0003, rd=0 → accepted, `issue_id_o`=0, `pending_o`=0x3 next cycle, `busy_o`=1.
- Slot 0 holds 0x3; issue rd=0x2 → `issue_ready_o`=0. Clear id 0 mask 0x2:
  - with bypass, accepted the same cycle;
  - without bypass, accepted the next cycle.
  - `pending_o`=0x1 in both cases.
- Partial clears on slot 0 (0x1, then 0x2) → `retire_valid_o` pulses once with id 0 the cycle after the second clear; `pending_o`=0, `busy_o`=0.
- Fill all 8 slots with disjoint single-vreg masks → `issue_ready_o`=0 for a non-zero mask but 1 for wr=0, rd=0. Retire slot 5 → the next issue gets id 5.
- Clear to a non-live slot, and clear bits outside the slot mask → no state change, no retire.
- Four slots live; assert `flush_i` together with an issue and a clear → next cycle `pending_o`=0, `busy_o`=0, no retire pulses, next issue gets id 0.

Source files
------------

// File: rtl/vproc_wr_scoreboard.sv
// vproc_wr_scoreboard: vector-register write scoreboard for the dispatch stage.
// Holds per-instruction pending-write masks in 2**SLOT_ID_W slots and stalls
// dispatch on RAW/WAW hazards. Writeback clears drain the masks. A slot whose
// mask drains to zero retires with a one-cycle pulse.
// Optional feature: define VPROC_WR_SB_CLEAR_BYPASS_EN to let a same-cycle
// clear lift the hazard it resolves. Without it, the waiting issue is accepted
// one cycle later.
module vproc_wr_scoreboard #(
  parameter int   SLOT_ID_W      = 3,
  parameter logic DONT_CARE_ZERO = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 sync_rst_i,
  input  logic                 flush_i,
  input  logic                 issue_valid_i,
  output logic                 issue_ready_o,
  input  logic [31:0]          issue_wr_mask_i,
  input  logic [31:0]          issue_rd_mask_i,
  output logic [SLOT_ID_W-1:0] issue_id_o,
  input  logic                 clear_valid_i,
  input  logic [SLOT_ID_W-1:0] clear_id_i,
  input  logic [31:0]          clear_mask_i,
  output logic [31:0]          pending_o,
  output logic                 retire_valid_o,
  output logic [SLOT_ID_W-1:0] retire_id_o,
  output logic                 busy_o
);

  localparam int NSLOT = 2 ** SLOT_ID_W;

  // Slot table and retire reporting registers
  logic [31:0]          mask_r [NSLOT];
  logic [NSLOT-1:0]     live_r;
  logic                 retire_valid_r;
  logic [SLOT_ID_W-1:0] retire_id_r;

  // Combinational helpers
  logic                 free_found_s;
  logic [SLOT_ID_W-1:0] free_idx_s;
  logic [31:0]          pend_s;
  logic [31:0]          pend_chk_s;
  logic                 clear_hit_s;
  logic [31:0]          clr_next_s;
  logic                 clr_empty_s;
  logic                 haz_s;
  logic                 ready_s;
  logic                 issue_alloc_s;

  // Lowest-index free slot; scanning downward lets the lowest index win
  always_comb begin
    free_found_s = 1'b0;
    free_idx_s   = {SLOT_ID_W{1'b0}};
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (!live_r[i]) begin
        free_found_s = 1'b1;
        free_idx_s   = SLOT_ID_W'(i);
      end else begin
        free_found_s = free_found_s;
      end
    end
  end

  // OR of all live slot masks, derived from registered state only
  always_comb begin
    pend_s = 32'h0000_0000;
    for (int i = 0; i < NSLOT; i++) begin
      pend_s = pend_s | (live_r[i] ? mask_r[i] : 32'h0000_0000);
    end
  end

  // Clear qualification; a clear to a non-live slot has no effect at all
  always_comb begin
    clear_hit_s = clear_valid_i && live_r[clear_id_i];
    clr_next_s  = mask_r[clear_id_i] & ~clear_mask_i;
    clr_empty_s = clear_hit_s && (clr_next_s == 32'h0000_0000);
  end

  // Hazard view of pending writes, optionally minus bits cleared this cycle
  always_comb begin
`ifdef VPROC_WR_SB_CLEAR_BYPASS_EN
    pend_chk_s = pend_s & ~(clear_hit_s ? clear_mask_i : 32'h0000_0000);
`else
    pend_chk_s = pend_s;
`endif
  end

  // Issue handshake: stall on hazard, on a full table, and while resetting
  always_comb begin
    haz_s = |((issue_rd_mask_i | issue_wr_mask_i) & pend_chk_s);
    if (sync_rst_i || flush_i) begin
      ready_s = 1'b0;
    end else begin
      ready_s = !haz_s && (free_found_s || (issue_wr_mask_i == 32'h0000_0000));
    end
    issue_alloc_s = issue_valid_i && ready_s && (issue_wr_mask_i != 32'h0000_0000);
  end

  // Allocated slot index; undefined when the table is full
  always_comb begin
    if (free_found_s) begin
      issue_id_o = free_idx_s;
    end else if (DONT_CARE_ZERO) begin
      issue_id_o = {SLOT_ID_W{1'b0}};
    end else begin
      issue_id_o = {SLOT_ID_W{1'bx}};
    end
  end

  // Slot table update: allocate, clear, retire; reset/flush drop everything
  always_ff @(posedge clk_i) begin
    if (sync_rst_i || flush_i) begin
      live_r         <= {NSLOT{1'b0}};
      retire_valid_r <= 1'b0;
      retire_id_r    <= {SLOT_ID_W{1'b0}};
      for (int i = 0; i < NSLOT; i++) begin
        mask_r[i] <= 32'h0000_0000;
      end
    end else begin
      for (int i = 0; i < NSLOT; i++) begin
        if (issue_alloc_s && (free_idx_s == SLOT_ID_W'(i))) begin
          mask_r[i] <= issue_wr_mask_i;
          live_r[i] <= 1'b1;
        end else if (clear_hit_s && (clear_id_i == SLOT_ID_W'(i))) begin
          mask_r[i] <= clr_next_s;
          live_r[i] <= !clr_empty_s;
        end else begin
          mask_r[i] <= mask_r[i];
          live_r[i] <= live_r[i];
        end
      end
      retire_valid_r <= clr_empty_s;
      retire_id_r    <= clr_empty_s ? clear_id_i : retire_id_r;
    end
  end

  assign issue_ready_o  = ready_s;
  assign pending_o      = pend_s;
  assign busy_o         = |live_r;
  assign retire_valid_o = retire_valid_r;
  assign retire_id_o    = retire_id_r;

endmodule
